// File: rtl/seg7_scan_driver_if.sv
// Bus between the datapath and the 7-segment scan driver: load/shadow inputs
// from the master, display pins and status back from the driver.
interface seg7_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   digits_in;
    logic [N_DIGITS-1:0]     dp_in;
    logic [6:0]              seg;
    logic                    dp;
    logic [N_DIGITS-1:0]     an;
    logic                    frame_tick;
    logic                    pending;

    modport master (
        output load, digits_in, dp_in,
        input  seg, dp, an, frame_tick, pending
    );

    modport slave (
        input  load, digits_in, dp_in,
        output seg, dp, an, frame_tick, pending
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex 7-segment driver with ghost-guard cycles,
// leading-zero blanking and frame-synchronous shadow loading.
module seg7_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int DIV            = 1000,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic   clk,
    input  logic   rst_n,
    seg7_if.slave  bus
);
    localparam int                  CNT_W    = $clog2(DIV);
    localparam int                  IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{1'b1}};
    localparam logic [N_DIGITS-1:0] AN_ONE0  = N_DIGITS'(1);
    localparam logic [6:0]          SEG_POL  = {7{SEG_ACTIVE_LOW}};
    localparam logic                DP_POL   = SEG_ACTIVE_LOW;

    typedef enum logic {
        PH_GUARD = 1'b0,
        PH_DRIVE = 1'b1
    } phase_t;

    phase_t                  r_phase;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*N_DIGITS-1:0]   r_shadow_dig;
    logic [N_DIGITS-1:0]     r_shadow_dp;
    logic [4*N_DIGITS-1:0]   r_active_dig;
    logic [N_DIGITS-1:0]     r_active_dp;
    logic                    r_pending;
    logic                    r_frame_tick;
    logic [N_DIGITS-1:0]     r_an;
    logic [6:0]              r_seg;
    logic                    r_dp;

    logic [N_DIGITS-1:0]     w_blank;
    logic [3:0]              w_nib;
    logic                    w_cur_dp;
    logic                    w_cur_blank;
    logic                    w_slot_end;
    logic                    w_boundary;

    function automatic logic [6:0] decode(input logic [3:0] nib);
        case (nib)
            4'h0:    decode = 7'h7E;
            4'h1:    decode = 7'h30;
            4'h2:    decode = 7'h6D;
            4'h3:    decode = 7'h79;
            4'h4:    decode = 7'h33;
            4'h5:    decode = 7'h5B;
            4'h6:    decode = 7'h5F;
            4'h7:    decode = 7'h70;
            4'h8:    decode = 7'h7F;
            4'h9:    decode = 7'h7B;
            4'hA:    decode = 7'h77;
            4'hB:    decode = 7'h1F;
            4'hC:    decode = 7'h4E;
            4'hD:    decode = 7'h3D;
            4'hE:    decode = 7'h4F;
            4'hF:    decode = 7'h47;
            default: decode = 7'h00;
        endcase
    endfunction

    assign w_nib       = r_active_dig[4*int'(r_idx) +: 4];
    assign w_cur_dp    = r_active_dp[r_idx];
    assign w_cur_blank = w_blank[r_idx];
    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_boundary  = w_slot_end && (r_idx == IDX_LAST);

    // Leading-zero run from the top digit down; a lit dp ends the run, digit 0 always shows.
    always_comb begin : blank_calc
        logic v_run;
        v_run   = 1'b1;
        w_blank = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            v_run = v_run & (r_active_dig[4*i +: 4] == 4'h0) & ~r_active_dp[i];
            if ((i > 0) && BLANK_LZ) begin
                w_blank[i] = v_run;
            end else begin
                w_blank[i] = 1'b0;
            end
        end
    end

    // Scan counters, slot phase and registered pin drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_phase <= PH_GUARD;
            r_an    <= AN_OFF;
            r_seg   <= SEG_POL;
            r_dp    <= DP_POL;
        end else begin
            if (w_slot_end) begin
                r_cnt   <= '0;
                r_idx   <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
                r_phase <= PH_GUARD;
            end else begin
                r_cnt   <= r_cnt + CNT_W'(1);
                r_phase <= PH_DRIVE;
            end

            if ((r_phase == PH_GUARD) || w_cur_blank) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_POL;
                r_dp  <= DP_POL;
            end else begin
                r_an  <= ~(AN_ONE0 << r_idx);
                r_seg <= decode(w_nib) ^ SEG_POL;
                r_dp  <= w_cur_dp ^ DP_POL;
            end
        end
    end

    // Shadow capture and frame-boundary transfer; a load on the boundary bypasses the shadow wait.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_dig <= '0;
            r_shadow_dp  <= '0;
            r_active_dig <= '0;
            r_active_dp  <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            if (bus.load) begin
                r_shadow_dig <= bus.digits_in;
                r_shadow_dp  <= bus.dp_in;
            end else begin
                r_shadow_dig <= r_shadow_dig;
                r_shadow_dp  <= r_shadow_dp;
            end

            if (w_boundary) begin
                r_frame_tick <= 1'b1;
                r_pending    <= 1'b0;
                if (bus.load) begin
                    r_active_dig <= bus.digits_in;
                    r_active_dp  <= bus.dp_in;
                end else if (r_pending) begin
                    r_active_dig <= r_shadow_dig;
                    r_active_dp  <= r_shadow_dp;
                end else begin
                    r_active_dig <= r_active_dig;
                    r_active_dp  <= r_active_dp;
                end
            end else begin
                r_frame_tick <= 1'b0;
                r_pending    <= r_pending | bus.load;
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;
    assign bus.pending    = r_pending;
endmodule
